// File: rtl/game_engine_mp.sv
// game_engine_mp: multi-board shot engine in front of external board memory and BFS sink unit.
// Define GAME_ENGINE_MP_DUP_CHECK_EN to add a per-cell shot map that answers repeats with DUP.
module game_engine_mp #(
    parameter int WIDTH       = 6,
    parameter int HEIGHT      = 6,
    parameter int NUM_PLAYERS = 2,
    parameter int CNT_W       = 8,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_game,
    input  logic [XW-1:0]          shot_x,
    input  logic [YW-1:0]          shot_y,
    input  logic [PW-1:0]          shot_player,
    input  logic                   shot_valid,
    output logic                   shot_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2:0]             res_code,
    output logic [PW-1:0]          res_player,
    output logic [CNT_W-1:0]       res_shots,
    output logic [NUM_PLAYERS-1:0] done,
    output logic [PW-1:0]          mem_player,
    output logic [XW-1:0]          mem_x,
    output logic [YW-1:0]          mem_y,
    output logic                   mem_req,
    input  logic                   mem_ack,
    input  logic [1:0]             mem_data,
    input  logic                   mem_empty,
    output logic                   bfs_start,
    output logic [PW-1:0]          bfs_player,
    input  logic                   bfs_sink,
    input  logic                   bfs_done
);

    localparam logic [2:0] C_MISS = 3'd0;
    localparam logic [2:0] C_HIT  = 3'd1;
    localparam logic [2:0] C_SINK = 3'd2;
    localparam logic [2:0] C_DUP  = 3'd3;
    localparam logic [2:0] C_OOR  = 3'd4;
    localparam logic [2:0] C_OVER = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_BFS,
        S_RESULT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt [NUM_PLAYERS];
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_inc;
    logic             lat_empty;
    logic             oor;
    logic             seen;
    logic             unused_mem;

    assign shot_ready = (state == S_IDLE) && !new_game;
    assign unused_mem = mem_data[1];

    assign oor = (int'(shot_x) >= WIDTH)
              || (int'(shot_y) >= HEIGHT)
              || (int'(shot_player) >= NUM_PLAYERS);

    // mem_* double as the latched shot address for the whole memory/BFS walk
    assign cnt_cur = cnt[mem_player];
    assign cnt_inc = (&cnt_cur) ? cnt_cur : cnt_cur + 1'b1;

`ifdef GAME_ENGINE_MP_DUP_CHECK_EN
    logic [WIDTH-1:0] shot_map [NUM_PLAYERS][HEIGHT];
    assign seen = shot_map[shot_player][shot_y][shot_x];
`else
    assign seen = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            res_valid  <= 1'b0;
            res_code   <= C_MISS;
            res_player <= '0;
            res_shots  <= '0;
            done       <= '0;
            mem_req    <= 1'b0;
            mem_x      <= '0;
            mem_y      <= '0;
            mem_player <= '0;
            bfs_start  <= 1'b0;
            bfs_player <= '0;
            lat_empty  <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) cnt[p] <= '0;
`ifdef GAME_ENGINE_MP_DUP_CHECK_EN
            for (int p = 0; p < NUM_PLAYERS; p++)
                for (int r = 0; r < HEIGHT; r++) shot_map[p][r] <= '0;
`endif
        end else begin
            mem_req <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (new_game) begin
                        done <= '0;
                        for (int p = 0; p < NUM_PLAYERS; p++) cnt[p] <= '0;
`ifdef GAME_ENGINE_MP_DUP_CHECK_EN
                        for (int p = 0; p < NUM_PLAYERS; p++)
                            for (int r = 0; r < HEIGHT; r++) shot_map[p][r] <= '0;
`endif
                    end else if (shot_valid) begin
                        res_player <= shot_player;
                        if (oor) begin
                            res_code  <= C_OOR;
                            res_shots <= '0;
                            res_valid <= 1'b1;
                            state     <= S_RESULT;
                        end else if (done[shot_player]) begin
                            res_code  <= C_OVER;
                            res_shots <= cnt[shot_player];
                            res_valid <= 1'b1;
                            state     <= S_RESULT;
                        end else if (seen) begin
                            res_code  <= C_DUP;
                            res_shots <= cnt[shot_player];
                            res_valid <= 1'b1;
                            state     <= S_RESULT;
                        end else begin
                            mem_req    <= 1'b1;
                            mem_x      <= shot_x;
                            mem_y      <= shot_y;
                            mem_player <= shot_player;
                            state      <= S_MEM_REQ;
                        end
                    end
                end
                S_MEM_REQ: begin
                    state <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    if (mem_ack) begin
                        cnt[mem_player] <= cnt_inc;
                        res_shots       <= cnt_inc;
`ifdef GAME_ENGINE_MP_DUP_CHECK_EN
                        shot_map[mem_player][mem_y][mem_x] <= 1'b1;
`endif
                        if (mem_data[0]) begin
                            lat_empty  <= mem_empty;
                            bfs_start  <= 1'b1;
                            bfs_player <= mem_player;
                            state      <= S_BFS;
                        end else begin
                            res_code  <= C_MISS;
                            res_valid <= 1'b1;
                            state     <= S_RESULT;
                        end
                    end
                end
                S_BFS: begin
                    if (bfs_done) begin
                        bfs_start <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= S_RESULT;
                        if (bfs_sink) begin
                            res_code <= C_SINK;
                            if (lat_empty) done[bfs_player] <= 1'b1;
                        end else begin
                            res_code <= C_HIT;
                        end
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_engine_mp.sv
// tb_game_engine_mp: directed vector table, hand sequences and random shots
// checked against a board-level model with its own memory and BFS responders.
`timescale 1ns/1ps
module tb_game_engine_mp;

    localparam int W  = 6;
    localparam int H  = 6;
    localparam int NP = 2;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int PW = 1;
    localparam int NC = NP * W * H;

    localparam int C_MISS = 0;
    localparam int C_HIT  = 1;
    localparam int C_SINK = 2;
    localparam int C_DUP  = 3;
    localparam int C_OOR  = 4;
    localparam int C_OVER = 5;

`ifdef GAME_ENGINE_MP_DUP_CHECK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif
    localparam int ADJ = DUP_EN ? 0 : 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          new_game;
    logic [XW-1:0] shot_x;
    logic [YW-1:0] shot_y;
    logic [PW-1:0] shot_player;
    logic          shot_valid;
    logic          shot_ready;
    logic          res_valid;
    logic          res_ready;
    logic [2:0]    res_code;
    logic [PW-1:0] res_player;
    logic [7:0]    res_shots;
    logic [NP-1:0] done;
    logic [PW-1:0] mem_player;
    logic [XW-1:0] mem_x;
    logic [YW-1:0] mem_y;
    logic          mem_req;
    logic          mem_ack;
    logic [1:0]    mem_data;
    logic          mem_empty;
    logic          bfs_start;
    logic [PW-1:0] bfs_player;
    logic          bfs_sink;
    logic          bfs_done;

    game_engine_mp dut (
        .clk(clk), .rst(rst), .new_game(new_game),
        .shot_x(shot_x), .shot_y(shot_y), .shot_player(shot_player),
        .shot_valid(shot_valid), .shot_ready(shot_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code),
        .res_player(res_player), .res_shots(res_shots), .done(done),
        .mem_player(mem_player), .mem_x(mem_x), .mem_y(mem_y),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
        .mem_empty(mem_empty), .bfs_start(bfs_start), .bfs_player(bfs_player),
        .bfs_sink(bfs_sink), .bfs_done(bfs_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit ship [NC];
    bit hitm [NC];
    int remain [NP];
    int cnt_m [NP];
    bit done_m [NP];
    bit seen_m [NC];
    bit sink_val;
    int bfs_delay;
    int mreq_cnt = 0;

    typedef struct {
        int x; int y; int p; bit sink;
        int code; int shots; int player; int lat; int mreq; int dn;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // zero-wait board memory: acks the cycle after mem_req
    initial begin
        bit pend;
        int idx;
        pend = 0;
        idx = 0;
        mem_ack = 0;
        mem_data = 0;
        mem_empty = 0;
        forever begin
            @(negedge clk);
            mem_ack = 0;
            mem_data = 0;
            mem_empty = 0;
            if (pend) begin
                mem_ack = 1;
                if (ship[idx] && !hitm[idx]) begin
                    hitm[idx] = 1;
                    remain[idx / (W * H)]--;
                    mem_data = 2'b01;
                end
                mem_empty = (remain[idx / (W * H)] == 0);
                pend = 0;
            end
            if (mem_req) begin
                pend = 1;
                idx = (int'(mem_player) * H + int'(mem_y)) * W + int'(mem_x);
                mreq_cnt++;
            end
        end
    end

    // BFS unit: answers after bfs_delay cycles of bfs_start
    initial begin
        int bc;
        bc = 0;
        bfs_done = 0;
        bfs_sink = 0;
        forever begin
            @(negedge clk);
            bfs_done = 0;
            bfs_sink = 0;
            if (bfs_start) begin
                if (bc >= bfs_delay) begin
                    bfs_done = 1;
                    bfs_sink = sink_val;
                    bc = 0;
                end else begin
                    bc++;
                end
            end else begin
                bc = 0;
            end
        end
    end

    task automatic do_shot(input int x, input int y, input int p,
                           input bit sink, input int hold,
                           output int code, output int shots,
                           output int player, output int lat,
                           output int mreq);
        int n;
        int base;
        n = 0;
        while (!shot_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        sink_val = sink;
        shot_x = XW'(x);
        shot_y = YW'(y);
        shot_player = PW'(p);
        shot_valid = 1'b1;
        base = mreq_cnt;
        @(negedge clk);
        shot_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        code = int'(res_code);
        shots = int'(res_shots);
        player = int'(res_player);
        repeat (hold) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        mreq = mreq_cnt - base;
    endtask

    task automatic model_shot(input int x, input int y, input int p,
                              input bit sink, output int ecode,
                              output int eshots, output int elat,
                              output int emreq);
        int idx;
        idx = (p * H + y) * W + x;
        elat = 1;
        emreq = 0;
        if (x >= W || y >= H || p >= NP) begin
            ecode = C_OOR;
            eshots = 0;
        end else if (done_m[p]) begin
            ecode = C_OVER;
            eshots = cnt_m[p];
        end else if (DUP_EN && seen_m[idx]) begin
            ecode = C_DUP;
            eshots = cnt_m[p];
        end else begin
            seen_m[idx] = 1;
            if (cnt_m[p] < 255) cnt_m[p]++;
            eshots = cnt_m[p];
            emreq = 1;
            if (ship[idx] && !hitm[idx]) begin
                elat = 4 + bfs_delay;
                if (sink) begin
                    ecode = C_SINK;
                    if (remain[p] == 1) done_m[p] = 1;
                end else begin
                    ecode = C_HIT;
                end
            end else begin
                ecode = C_MISS;
                elat = 3;
            end
        end
    endtask

    task automatic post_checks(input string tag, input int dn);
        chk({tag, " done"}, int'(done), dn);
        chk({tag, " shot_ready"}, int'(shot_ready), 1);
        chk({tag, " res_valid"}, int'(res_valid), 0);
    endtask

    initial begin
        int code, shots, player, lat, mreq, n, base;
        int x, y, p, ec, es, el, em, hold;
        bit sk;

        vt[0] = '{2, 3, 0, 1'b0, C_MISS, 1, 0, 3, 1, 0};
        vt[1] = '{0, 0, 1, 1'b0, C_HIT, 1, 1, 6, 1, 0};
        vt[2] = '{0, 1, 1, 1'b1, C_SINK, 2, 1, 6, 1, 2};
        vt[3] = '{0, 0, 1, 1'b0, C_OVER, 2, 1, 1, 0, 2};
        vt[4] = '{6, 0, 0, 1'b0, C_OOR, 0, 0, 1, 0, 2};
        vt[5] = '{2, 3, 0, 1'b0, DUP_EN ? C_DUP : C_MISS, 1 + ADJ, 0,
                  DUP_EN ? 1 : 3, ADJ, 2};
        vt[6] = '{3, 7, 1, 1'b0, C_OOR, 0, 1, 1, 0, 2};
        vt[7] = '{5, 4, 0, 1'b0, C_MISS, 2 + ADJ, 0, 3, 1, 2};

        for (int i = 0; i < NC; i++) begin
            ship[i] = 0;
            hitm[i] = 0;
        end
        ship[(0 * H + 5) * W + 5] = 1;
        ship[(1 * H + 0) * W + 0] = 1;
        ship[(1 * H + 1) * W + 0] = 1;
        remain[0] = 1;
        remain[1] = 2;
        bfs_delay = 2;
        sink_val = 0;

        rst = 1;
        new_game = 0;
        shot_x = 0;
        shot_y = 0;
        shot_player = 0;
        shot_valid = 0;
        res_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst shot_ready", int'(shot_ready), 1);
        chk("rst res_valid", int'(res_valid), 0);
        chk("rst res_code", int'(res_code), 0);
        chk("rst res_player", int'(res_player), 0);
        chk("rst res_shots", int'(res_shots), 0);
        chk("rst done", int'(done), 0);
        chk("rst mem_req", int'(mem_req), 0);
        chk("rst mem_addr", int'({mem_player, mem_x, mem_y}), 0);
        chk("rst bfs_start", int'(bfs_start), 0);
        chk("rst bfs_player", int'(bfs_player), 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_shot(vt[i].x, vt[i].y, vt[i].p, vt[i].sink, 0,
                    code, shots, player, lat, mreq);
            chk($sformatf("v%0d code", i), code, vt[i].code);
            chk($sformatf("v%0d shots", i), shots, vt[i].shots);
            chk($sformatf("v%0d player", i), player, vt[i].player);
            chk($sformatf("v%0d latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d mem_req", i), mreq, vt[i].mreq);
            post_checks($sformatf("v%0d", i), vt[i].dn);
        end

        // result held back by the consumer for 5 cycles
        shot_x = 4;
        shot_y = 4;
        shot_player = 0;
        shot_valid = 1;
        @(negedge clk);
        shot_valid = 0;
        n = 1;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold latency", n, 3);
        repeat (5) begin
            @(negedge clk);
            chk("hold res_valid", int'(res_valid), 1);
            chk("hold res_code", int'(res_code), C_MISS);
            chk("hold res_shots", int'(res_shots), 3 + ADJ);
            chk("hold res_player", int'(res_player), 0);
            chk("hold shot_ready", int'(shot_ready), 0);
        end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk("release shot_ready", int'(shot_ready), 1);
        chk("release res_valid", int'(res_valid), 0);

        // reset while the BFS unit is busy
        bfs_delay = 20;
        shot_x = 5;
        shot_y = 5;
        shot_player = 0;
        shot_valid = 1;
        @(negedge clk);
        shot_valid = 0;
        n = 0;
        while (!bfs_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bfs_start raised", int'(bfs_start), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst-bfs bfs_start", int'(bfs_start), 0);
        chk("rst-bfs done", int'(done), 0);
        chk("rst-bfs res_valid", int'(res_valid), 0);
        chk("rst-bfs shot_ready", int'(shot_ready), 1);
        bfs_delay = 2;
        repeat (2) @(negedge clk);
        do_shot(1, 1, 0, 0, 0, code, shots, player, lat, mreq);
        chk("after-rst b0 code", code, C_MISS);
        chk("after-rst b0 shots", shots, 1);
        do_shot(0, 0, 1, 0, 0, code, shots, player, lat, mreq);
        chk("after-rst b1 code", code, C_MISS);
        chk("after-rst b1 shots", shots, 1);

        // new_game with a shot offered in the same cycle
        do_shot(2, 2, 0, 0, 0, code, shots, player, lat, mreq);
        chk("pre-ng shots", shots, 2);
        base = mreq_cnt;
        shot_x = 2;
        shot_y = 2;
        shot_player = 0;
        shot_valid = 1;
        new_game = 1;
        #1;
        chk("ng shot_ready", int'(shot_ready), 0);
        @(negedge clk);
        new_game = 0;
        shot_valid = 0;
        repeat (3) @(negedge clk);
        chk("ng res_valid", int'(res_valid), 0);
        chk("ng mem_req count", mreq_cnt - base, 0);
        chk("ng shot_ready", int'(shot_ready), 1);
        do_shot(2, 2, 0, 0, 0, code, shots, player, lat, mreq);
        chk("post-ng code", code, C_MISS);
        chk("post-ng shots", shots, 1);

        // random games on fresh boards
        for (int i = 0; i < NC; i++) begin
            ship[i] = ($urandom_range(0, 3) == 0);
            hitm[i] = 0;
            seen_m[i] = 0;
        end
        for (int q = 0; q < NP; q++) begin
            remain[q] = 0;
            cnt_m[q] = 0;
            done_m[q] = 0;
            for (int i = 0; i < W * H; i++) remain[q] += int'(ship[q * W * H + i]);
        end
        new_game = 1;
        @(negedge clk);
        new_game = 0;
        for (int i = 0; i < 160; i++) begin
            x = $urandom_range(0, 6);
            y = $urandom_range(0, 6);
            p = $urandom_range(0, 1);
            sk = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 2);
            bfs_delay = $urandom_range(0, 3);
            model_shot(x, y, p, sk, ec, es, el, em);
            do_shot(x, y, p, sk, hold, code, shots, player, lat, mreq);
            chk($sformatf("r%0d code", i), code, ec);
            chk($sformatf("r%0d shots", i), shots, es);
            chk($sformatf("r%0d player", i), player, p);
            chk($sformatf("r%0d latency", i), lat, el);
            chk($sformatf("r%0d mem_req", i), mreq, em);
            post_checks($sformatf("r%0d", i), int'({done_m[1], done_m[0]}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/game_engine_mp.md
# game_engine_mp

Parametrised, multi-board successor of the submarine game engine. It accepts shots addressed to one of `NUM_PLAYERS` boards of configurable size and queries the external board memory. On a ship cell it runs the external sink-detection (BFS) unit. Each shot returns one coded result through a valid/ready handshake, and the block keeps per-board shot counters and per-board game-over flags.

## Interface
- `WIDTH`, 6, board columns (x range 0..WIDTH-1), 2..16
- `HEIGHT`, 6, board rows (y range 0..HEIGHT-1), 2..16
- `NUM_PLAYERS`, 2, number of independent boards, 1..4
- `CNT_W`, 8, shot counter width
- Derived widths: `XW=$clog2(WIDTH)`, `YW=$clog2(HEIGHT)`, `PW=max(1,$clog2(NUM_PLAYERS))`
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `new_game` in 1: clears all boards' state (shot map, counters, done)
- `shot_x` in XW: shot column
- `shot_y` in YW: shot row
- `shot_player` in PW: target board
- `shot_valid` in 1: shot offered
- `shot_ready` out 1: engine can accept a shot
- `res_valid` out 1: result available
- `res_ready` in 1: result consumer ready
- `res_code` out 3: result code, one of:
  - 0 MISS, 1 HIT, 2 SINK, 3 DUP, 4 OOR (out of range), 5 OVER (board already done)
- `res_player` out PW: board of the result
- `res_shots` out CNT_W: that board's counter after this shot
- `done` out NUM_PLAYERS: sticky per-board all-sunk flag
- `mem_player` out PW: memory board select
- `mem_x` out XW: memory column
- `mem_y` out YW: memory row
- `mem_req` out 1: one-cycle request pulse
- `mem_ack` in 1: `mem_data`/`mem_empty` valid
- `mem_data` in 2: bit0 = ship present; bit1 unused
- `mem_empty` in 1: no intact ship cells remain on the requested board
- `bfs_start` out 1: level, held until `bfs_done`
- `bfs_player` out PW: board for the BFS unit
- `bfs_sink` in 1: ship fully sunk; valid with `bfs_done`
- `bfs_done` in 1: BFS complete

## Operation
- States:
  - IDLE: `shot_ready=1` unless `new_game`.
  - MEM_REQ
  - MEM_WAIT
  - BFS
  - RESULT
- IDLE, `new_game=1`:
  - Clears shot map, counters and `done`.
  - Shot not accepted that cycle.
  - `new_game` in any other state is ignored.
- IDLE, accept (`shot_valid&&shot_ready`) latches x/y/player, then checks in priority order:
  - x≥WIDTH, y≥HEIGHT or player≥NUM_PLAYERS → RESULT with OOR.
  - `done[player]` → RESULT with OVER.
  - Cell already in shot map → RESULT with DUP.
  - Otherwise → MEM_REQ.
- MEM_REQ:
  - Drives `mem_req=1` for one cycle with the latched address, then → MEM_WAIT.
- MEM_WAIT on `mem_ack`:
  - Marks the shot map and increments the counter (saturating at 2^CNT_W-1).
  - `mem_data[0]=0` → RESULT with MISS.
  - `mem_data[0]=1` → BFS, capturing `mem_empty`.
- BFS:
  - Holds `bfs_start=1` until `bfs_done`.
  - `bfs_sink=1` → SINK; also sets `done[player]` when the captured `mem_empty=1`.
  - `bfs_sink=0` → HIT.
  - Then → RESULT.
- RESULT:
  - `res_valid=1`; result fields stable.
  - Leaves on `res_valid&&res_ready` → IDLE.
- DUP, OOR and OVER shots do not touch memory or counters. `res_shots` reports the current count; it reports 0 for OOR.
- `rst`:
  - Any state → IDLE next edge.
  - Pending memory/BFS transactions are abandoned.
  - Shot map, counters and `done` are cleared.

## Timing
- Reset values:
  - `shot_ready=1` (IDLE)
  - `res_valid=0`, `res_code=0`, `res_player=0`, `res_shots=0`
  - `done=0`
  - `mem_req=0`, `mem_x/mem_y/mem_player=0`
  - `bfs_start=0`, `bfs_player=0`
- `shot_ready` is combinational on state and `new_game`; all other outputs are registered.
- MISS latency with zero-wait memory (`mem_ack` the cycle after `mem_req`): accept edge → `res_valid` 3 cycles later.
- HIT/SINK latency: MISS latency + BFS cycles + 1.
- DUP/OOR/OVER: `res_valid` 1 cycle after accept.
- Back-to-back: `shot_ready` returns 1 in the cycle after the result handshake. At most one shot is outstanding.
- `mem_ack` or `bfs_done` arriving outside MEM_WAIT/BFS is ignored.
- `res_ready` held high gives a one-cycle `res_valid` pulse.

## Configuration
- `GAME_ENGINE_MP_DUP_CHECK_EN` defined:
  - Shot map of NUM_PLAYERS·WIDTH·HEIGHT bits is instantiated.
  - Repeated cells return DUP without memory access.
- Undefined:
  - No shot map; DUP is never produced.
  - Every in-range shot on a not-done board goes to memory and is counted.
  - Memory is responsible for re-hit semantics.

## Test plan
- Reset, board 0, shot (2,3) on water (`mem_data=0`) → MISS, `res_player=0`, `res_shots=1`, latency 3 cycles.
- Board 1, 2-cell ship at (0,0),(0,1):
  - Shot (0,0), `bfs_sink=0` → HIT.
  - Shot (0,1), `bfs_sink=1`, `mem_empty=1` → SINK, `done=2'b10`.
  - Next shot to board 1 → OVER.
- Shot x=6 with WIDTH=6 → OOR, no `mem_req`, `res_shots=0`.
- With the macro: repeat (2,3) on board 0 → DUP, `res_shots` stays 1. Without the macro: → `mem_req` issued, `res_shots=2`.
- Hold `res_ready=0` for 5 cycles → `res_valid` and fields stable, `shot_ready=0`. Release → IDLE next cycle.
- Assert `rst` during BFS → `bfs_start=0` next cycle, `done=0`, counters 0. Then assert `new_game` in IDLE with `shot_valid=1` → shot not accepted.
